// File: rtl/demux_route_sequencer_if.sv
// Upstream word handshake plus demux select / buffer-write bus of the route sequencer.
// The sequencer takes the slave side; the word source / buffer side takes master.
interface demux_route_sequencer_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        sel;
  logic [2:0]        wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    output in_valid,
    input  in_ready,
    input  sel,
    input  wr_en,
    input  wr_addr
  );

  modport slave (
    input  in_valid,
    output in_ready,
    output sel,
    output wr_en,
    output wr_addr
  );
endinterface

// File: rtl/demux_route_sequencer.sv
// Sequences one load of pixel, weight and bias buffers from a single word stream,
// skipping zero-length phases and pulsing done once all programmed words are written.
module demux_route_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_W:0]         len0,
  input  logic [ADDR_W:0]         len1,
  input  logic [ADDR_W:0]         len2,
  output logic                    busy,
  output logic                    done,
  demux_route_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PH0,
    S_PH1,
    S_PH2,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sel_q, sel_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [2:0][ADDR_W:0]   len_q, len_d;
  logic [2:0][ADDR_W:0]   len_in;
  logic [2:0]             len_nz;
  logic [2:0]             in_nz;
  logic [2:0]             phase_act;
  logic                   in_ready;
  logic                   xfer;
  logic                   last;
  logic [ADDR_W:0]        cur_len;
  logic [ADDR_W:0]        addr_inc;

  // Lowest-numbered candidate phase wins; no candidate means the load is complete.
  function automatic state_t pick_phase(input logic [2:0] cand);
    if (cand[0]) begin
      return S_PH0;
    end else if (cand[1]) begin
      return S_PH1;
    end else if (cand[2]) begin
      return S_PH2;
    end
    return S_DONE;
  endfunction

  assign len_in    = {len2, len1, len0};
  assign phase_act = {state_q == S_PH2, state_q == S_PH1, state_q == S_PH0};
  assign in_ready  = |phase_act;
  assign xfer      = bus.in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_phase
      assign bus.wr_en[gi] = phase_act[gi] & xfer;
      assign len_nz[gi]    = |len_q[gi];
      assign in_nz[gi]     = |len_in[gi];
    end
  endgenerate

  always_comb begin
    cur_len = '0;
    case (state_q)
      S_PH0:   cur_len = len_q[0];
      S_PH1:   cur_len = len_q[1];
      S_PH2:   cur_len = len_q[2];
      default: cur_len = '0;
    endcase
  end

  // Full-width compare so a length of 2**ADDR_W ends at the top address without wrapping.
  assign addr_inc = {1'b0, addr_q} + (ADDR_W+1)'(1);
  assign last     = (addr_inc == cur_len);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;

    if (xfer) begin
      addr_d = last ? '0 : addr_q + ADDR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          len_d   = len_in;
          addr_d  = '0;
          state_d = pick_phase(in_nz);
        end
      end
      S_PH0: begin
        if (xfer && last) state_d = pick_phase(len_nz & 3'b110);
      end
      S_PH1: begin
        if (xfer && last) state_d = pick_phase(len_nz & 3'b100);
      end
      S_PH2: begin
        if (xfer && last) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Cancel overrides any phase advance; the word accepted this cycle is still written.
    if (abort) begin
      state_d = S_IDLE;
      addr_d  = '0;
    end
  end

  always_comb begin
    sel_d = 2'd3;
    case (state_d)
      S_PH0:   sel_d = 2'd0;
      S_PH1:   sel_d = 2'd1;
      S_PH2:   sel_d = 2'd2;
      default: sel_d = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd3;
      addr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.sel      = sel_q;
  assign bus.wr_addr  = addr_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);

endmodule

// File: tb/tb_demux_route_sequencer.sv
// Directed and randomized loads of the route sequencer, checked cycle by cycle
// against a queue of expected (buffer, address) writes.
module tb_demux_route_sequencer;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   len0 = '0;
  logic [ADDR_W:0]   len1 = '0;
  logic [ADDR_W:0]   len2 = '0;
  logic              busy;
  logic              done;

  demux_route_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  demux_route_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .len0    (len0),
    .len1    (len1),
    .len2    (len2),
    .busy    (busy),
    .done    (done),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int b;
    int a;
  } wr_t;

  wr_t q[$];
  bit  m_active = 1'b0;
  bit  m_done   = 1'b0;
  int  errors   = 0;
  int  checks   = 0;
  int  cyc      = 0;
  int  last_done_cyc = -1;
  int  wr_cnt   = 0;
  int  wr1_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_outputs();
    bit          rdy;
    logic [31:0] e_sel;
    logic [31:0] e_wr;
    rdy   = m_active && (q.size() > 0);
    e_sel = rdy ? q[0].b : 3;
    e_wr  = (rdy && bus.in_valid) ? (32'd1 << q[0].b) : 32'd0;
    chk("in_ready", bus.in_ready, rdy);
    chk("sel", bus.sel, e_sel);
    chk("wr_en", bus.wr_en, e_wr);
    if (rdy) chk("wr_addr", bus.wr_addr, q[0].a);
    chk("busy", busy, m_active || m_done);
    chk("done", done, m_done);
    if (done === 1'b1) last_done_cyc = cyc;
    if (bus.wr_en !== 3'b000) wr_cnt++;
    if (bus.wr_en[1] === 1'b1) wr1_cnt++;
  endtask

  task automatic model_step();
    int lens[3];
    if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (bus.in_valid) void'(q.pop_front());
      if (abort) begin
        m_active = 1'b0;
        q.delete();
      end else if (q.size() == 0) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else if (start && !abort) begin
      lens = '{int'(len0), int'(len1), int'(len2)};
      for (int b = 0; b < 3; b++)
        for (int a = 0; a < lens[b]; a++) q.push_back('{b, a});
      if (q.size() == 0) m_done = 1'b1;
      else m_active = 1'b1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: in_valid held high; mode 1: random in_valid, random stray starts and lengths.
  task automatic run_load(input int l0, input int l1, input int l2, input int mode, input int abort_rate);
    len0 = (ADDR_W+1)'(l0);
    len1 = (ADDR_W+1)'(l1);
    len2 = (ADDR_W+1)'(l2);
    start = 1'b1;
    bus.in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    cycle();
    start = 1'b0;
    for (int n = 0; n < 3000 && (m_active || m_done); n++) begin
      if (mode == 0) begin
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = ($urandom_range(0, 9) < 7);
        start = ($urandom_range(0, 3) == 0);
        len0 = (ADDR_W+1)'($urandom_range(0, 5));
        len1 = (ADDR_W+1)'($urandom_range(0, 5));
        len2 = (ADDR_W+1)'($urandom_range(0, 5));
      end
      abort = (abort_rate != 0) && ($urandom_range(0, abort_rate - 1) == 0);
      cycle();
    end
    start = 1'b0;
    abort = 1'b0;
    bus.in_valid = 1'b0;
    chk("load_ended_busy", busy, 0);
  endtask

  initial begin
    int s_cyc;
    int w0;
    bus.in_valid = 1'b0;

    // Reset state
    #12;
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_sel", bus.sel, 3);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();
    cycle();

    // 1: 4/3/2 words with valid held high, done 10 edges after the start cycle
    s_cyc = cyc;
    w0 = wr_cnt;
    run_load(4, 3, 2, 0, 0);
    chk("t1_done_latency", last_done_cyc - s_cyc, 10);
    chk("t1_writes", wr_cnt - w0, 9);
    cycle();

    // 2: PH1 skipped
    w0 = wr1_cnt;
    run_load(2, 0, 2, 0, 0);
    chk("t2_no_wr1", wr1_cnt - w0, 0);
    cycle();

    // 3: all lengths zero
    s_cyc = cyc;
    w0 = wr_cnt;
    run_load(0, 0, 0, 0, 0);
    chk("t3_done_latency", last_done_cyc - s_cyc, 1);
    chk("t3_no_writes", wr_cnt - w0, 0);
    cycle();

    // 4: stall inside PH0
    w0 = wr_cnt;
    len0 = 2; len1 = 0; len2 = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    bus.in_valid = 1'b1; cycle();
    bus.in_valid = 1'b0; cycle();
    bus.in_valid = 1'b0; cycle();
    bus.in_valid = 1'b1; cycle();
    bus.in_valid = 1'b0; cycle();
    cycle();
    chk("t4_writes", wr_cnt - w0, 2);

    // 5: abort in PH1 at addr 2, then a fresh load
    len0 = 2; len1 = 4; len2 = 2;
    start = 1'b1;
    bus.in_valid = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t5_sel_before_abort", bus.sel, 1);
    chk("t5_addr_before_abort", bus.wr_addr, 2);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    run_load(3, 1, 1, 0, 0);
    cycle();

    // 6: asynchronous reset mid-PH2
    len0 = 1; len1 = 1; len2 = 5;
    start = 1'b1;
    bus.in_valid = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("t6_in_ph2", bus.sel, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_sel", bus.sel, 3);
    chk("t6_rst_wr_en", bus.wr_en, 0);
    chk("t6_rst_wr_addr", bus.wr_addr, 0);
    chk("t6_rst_in_ready", bus.in_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    m_active = 1'b0;
    m_done   = 1'b0;
    q.delete();
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle();

    // Full-depth phase: final write at address 2**ADDR_W - 1
    w0 = wr_cnt;
    run_load(1 << ADDR_W, 0, 0, 0, 0);
    chk("t6_full_writes", wr_cnt - w0, 1 << ADDR_W);
    cycle();

    // Randomized loads with stalls, stray starts and occasional aborts
    for (int i = 0; i < 14; i++) begin
      run_load($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 6), 1, 25);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
